// File: rtl/leaky_relu_seq.sv
// Burst sequencer: streams LEN words from the accumulator buffer through a shared
// LeakyReLU unit into the output buffer. Optional RELU_STATS_EN adds neg_count.
module leaky_relu_seq #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_rd,
    input  logic [ADDR_W-1:0] base_wr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              error,
`ifdef RELU_STATS_EN
    output logic [ADDR_W:0]   neg_count,
`endif
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              act_valid,
    output logic [DATA_W-1:0] act_x,
    input  logic [DATA_W-1:0] act_y,
    input  logic              act_done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0] ONE = 1;

    typedef enum logic [2:0] {IDLE, RD, RDW, ISSUE, WAIT, WR, FIN} state_t;

    state_t            state, nxt;
    logic [ADDR_W-1:0] base_rd_r, base_wr_r;
    logic [ADDR_W:0]   len_r, idx;
    logic [DATA_W-1:0] x_r, y_r;
    logic [CW-1:0]     wcnt;
    logic              last, tmo;

    assign last    = (idx == len_r - ONE);
    assign tmo     = (wcnt == CW'(TIMEOUT));
    assign busy    = (state != IDLE);
    assign rd_addr = base_rd_r + idx[ADDR_W-1:0];
    assign wr_addr = base_wr_r + idx[ADDR_W-1:0];
    assign act_x   = x_r;
    assign wr_data = y_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt       = state;
        rd_en     = 1'b0;
        act_valid = 1'b0;
        wr_en     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:  if (start) nxt = (len == '0) ? FIN : RD;
            RD:    begin rd_en = 1'b1; nxt = RDW; end
            RDW:   nxt = ISSUE;
            ISSUE: begin act_valid = 1'b1; nxt = WAIT; end
            WAIT:  begin
                if (act_done) nxt = WR;
                else if (tmo) nxt = FIN;
            end
            WR:    begin wr_en = 1'b1; nxt = last ? FIN : RD; end
            FIN:   begin done = 1'b1; nxt = IDLE; end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_rd_r <= '0;
            base_wr_r <= '0;
            len_r     <= '0;
            idx       <= '0;
            x_r       <= '0;
            y_r       <= '0;
            wcnt      <= '0;
            error     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start && len != '0) begin
                    base_rd_r <= base_rd;
                    base_wr_r <= base_wr;
                    len_r     <= len;
                    idx       <= '0;
                    error     <= 1'b0;
                end
                RDW:   x_r  <= rd_data;
                ISSUE: wcnt <= CW'(1);
                WAIT: begin
                    // act_done wins over a timeout landing in the same cycle
                    if (act_done) y_r   <= act_y;
                    else if (tmo) error <= 1'b1;
                    else          wcnt  <= wcnt + CW'(1);
                end
                WR: if (!last) idx <= idx + ONE;
                default: ;
            endcase
        end
    end

`ifdef RELU_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        neg_count <= '0;
        else if (state == IDLE && start)   neg_count <= '0;
        else if (state == ISSUE && x_r[DATA_W-1]) neg_count <= neg_count + ONE;
    end
`endif

endmodule

// File: doc/leaky_relu_seq.md
Name: leaky_relu_seq

Overview:
- Burst controller that streams LEN signed 32-bit accumulator words from an activation buffer through a single shared LeakyReLU unit, one element at a time.
- Writes each activated result into an output buffer.
- Sits between the conv accumulator SRAM and the post-activation buffer in the DPU layer pipeline.
- Fully handshaked with the LeakyReLU unit (valid/done), so it tolerates any unit latency.

Parameters:
- ADDR_W, 10, buffer address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 32, signed data width of buffers and activation unit.
- TIMEOUT, 15, maximum cycles to wait for act_done after act_valid before aborting.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  burst request; sampled only in IDLE.
- base_rd  in  ADDR_W  first read address.
- base_wr  in  ADDR_W  first write address.
- len  in  ADDR_W+1  element count, 0..2^ADDR_W.
- busy  out  1  high from the cycle after start is accepted until return to IDLE.
- done  out  1  one-cycle completion pulse (normal or abort).
- error  out  1  sticky timeout flag.
- rd_en  out  1  buffer read strobe; rd_data valid the cycle after.
- rd_addr  out  ADDR_W  read address.
- rd_data  in  DATA_W  read data.
- act_valid  out  1  one-cycle request to LeakyReLU unit.
- act_x  out  DATA_W  operand to unit.
- act_y  in  DATA_W  unit result, valid when act_done=1.
- act_done  in  1  unit completion.
- wr_en  out  1  write strobe.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  DATA_W  write data.

Behaviour:
- Reset (asynchronous, takes effect immediately mid-burst):
  - All outputs 0, state IDLE, idx=0, error=0.
  - No pulse is completed.
- FSM states: IDLE, RD, RDW, ISSUE, WAIT, WR, FIN.
- IDLE:
  - start=1 with len!=0: latch base_rd, base_wr, len; idx=0; clear error; go to RD.
  - start=1 with len==0: go to FIN (done pulse next cycle, no buffer traffic).
- RD: rd_en=1 for exactly one cycle, rd_addr=base_rd+idx (truncated to ADDR_W); go to RDW.
- RDW: capture rd_data into act_x register; go to ISSUE.
- ISSUE: act_valid=1 for exactly one cycle; act_x stays stable until act_done is seen; go to WAIT.
- WAIT:
  - act_done is sampled from the cycle after ISSUE; an act_done in the ISSUE cycle is ignored.
  - On act_done: capture act_y; go to WR.
  - The wait counter runs from 1 to TIMEOUT. If TIMEOUT WAIT cycles elapse without act_done: error=1, go to FIN (abort); no write for that element.
- WR:
  - wr_en=1 for one cycle, wr_addr=base_wr+idx (wrapping), wr_data=captured act_y.
  - If idx==len-1 go to FIN; else idx++ and go to RD.
- FIN: done=1 for one cycle; go to IDLE.
- busy=1 in every state except IDLE.
- Throughput: with unit latency L (act_done L cycles after act_valid), each element takes L+4 cycles; consecutive wr_en pulses are exactly L+4 cycles apart.
- start while busy is ignored; it is not queued.
- Data passes through unmodified; no arithmetic on data other than address addition.
- act_valid, rd_en, wr_en and done are mutually exclusive in any cycle.

Optional Feature:
- Macro RELU_STATS_EN.
- Defined:
  - Adds output neg_count (ADDR_W+1 bits), cleared on an accepted start.
  - Increments in the ISSUE cycle when act_x[DATA_W-1]=1.
  - Holds its value after done until the next accepted start; reset to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Bench model for all scenarios: unit y = x>=0 ? x : x>>>3, done 2 cycles after valid.
- len=3, base_rd=0, base_wr=100, mem[0..2]={-80,40,0} -> writes {-10,40,0} to 100..102, wr_en pulses 6 cycles apart, one done pulse, busy low after, error=0.
- start with len=0 -> done pulse exactly 1 cycle after start sampled; no rd_en/act_valid/wr_en ever asserted.
- ADDR_W=10, base_rd=1022, base_wr=1023, len=4 -> rd_addr sequence 1022,1023,0,1; wr_addr sequence 1023,0,1,2.
- Model holds act_done=0 -> after 15 WAIT cycles error=1 and done pulses; zero wr_en; next start with len=1 clears error and completes normally.
- start pulsed during a busy burst -> ignored, burst length unchanged; rst_n low mid-WAIT -> all outputs 0 immediately, FSM in IDLE, no done pulse.
- RELU_STATS_EN defined, inputs {-80,40,-1,0} -> outputs {-10,40,-1,0}, neg_count=2 after done.
